// File: rtl/sat_pkg.sv
// Shared types for the SAT solver datapath: variable indices, trail entries
// and the implication-stack state encoding.
package sat_pkg;

    localparam int MAX_VAR_COUNT = 512;
    localparam int SAT_VAR_IDX_W = 9;

    typedef logic [SAT_VAR_IDX_W-1:0] var_idx_t;

    typedef struct packed {
        var_idx_t var_idx;
        logic     val;
        logic     decision;
    } imply_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DONE
    } imply_stack_state_e;

endpackage

// File: rtl/imply_stack_mem.sv
// Flop-array LIFO storage: one synchronous write port at the push pointer,
// one combinational read port at the top-of-stack pointer.
module imply_stack_mem
    import sat_pkg::*;
#(
    parameter  int DEPTH = MAX_VAR_COUNT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_ptr,
    input  imply_entry_t  wr_entry,
    input  logic [AW-1:0] rd_ptr,
    output imply_entry_t  rd_entry
);

    imply_entry_t mem [DEPTH];

    // NOTE: storage is deliberately left out of reset; the pointer alone
    // defines which entries are live, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/imply_stack.sv
// Assignment trail for the solver: pushes implications/decisions, and on a
// backtrack streams entries out newest-first down to the latest decision.
module imply_stack
    import sat_pkg::*;
#(
    parameter  int VAR_IDX_W = SAT_VAR_IDX_W,
    parameter  int DEPTH     = MAX_VAR_COUNT,
    localparam int PTR_W     = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push_en,
    input  logic [VAR_IDX_W-1:0] push_var_idx,
    input  logic                 push_val,
    input  logic                 push_decision,
    input  logic                 backtrack_req,
    input  logic                 flush,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [VAR_IDX_W-1:0] pop_var_idx,
    output logic                 pop_val,
    output logic                 pop_decision,
    output logic                 busy,
    output logic                 bt_done,
    output logic                 bt_no_decision,
    output logic [PTR_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow
);

    localparam int AW = $clog2(DEPTH);

    imply_stack_state_e state;
    logic [PTR_W-1:0]   sp;
    logic               no_dec;
    logic               wr_en;
    imply_entry_t       wr_entry;
    imply_entry_t       rd_entry;

    assign count = sp;
    assign full  = (sp == PTR_W'(DEPTH));
    assign empty = (sp == '0);

    assign wr_en    = (state == IDLE) && push_en && !full && !flush;
    assign wr_entry = '{var_idx: var_idx_t'(push_var_idx), val: push_val, decision: push_decision};

    imply_stack_mem #(.DEPTH(DEPTH)) u_mem (
        .clock    (clock),
        .wr_en    (wr_en),
        .wr_ptr   (AW'(sp)),
        .wr_entry (wr_entry),
        .rd_ptr   (AW'(sp - PTR_W'(1))),
        .rd_entry (rd_entry)
    );

    // Pop side is gated by state so it reads as all-zero whenever not popping,
    // including immediately on asynchronous reset.
    assign pop_valid      = (state == POP);
    assign pop_var_idx    = pop_valid ? VAR_IDX_W'(rd_entry.var_idx) : '0;
    assign pop_val        = pop_valid & rd_entry.val;
    assign pop_decision   = pop_valid & rd_entry.decision;
    assign busy           = (state != IDLE);
    assign bt_done        = (state == DONE);
    assign bt_no_decision = bt_done & no_dec;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below sees the pre-edge sp/state regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sp       <= '0;
            no_dec   <= 1'b0;
            overflow <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            sp       <= '0;
            no_dec   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push_en) begin
                        if (!full) sp <= sp + PTR_W'(1);
                        else       overflow <= 1'b1;
                    end
                    // A same-cycle push lands first, so the stack is only
                    // truly empty when nothing was pushed.
                    if (backtrack_req) begin
                        if (empty && !push_en) begin
                            state  <= DONE;
                            no_dec <= 1'b1;
                        end else begin
                            state <= POP;
                        end
                    end
                end
                POP: begin
                    if (push_en) overflow <= 1'b1;
                    if (pop_ready) begin
                        sp <= sp - PTR_W'(1);
                        if (rd_entry.decision) begin
                            state  <= DONE;
                            no_dec <= 1'b0;
                        end else if (sp == PTR_W'(1)) begin
                            state  <= DONE;
                            no_dec <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (push_en) overflow <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/imply_stack.md
Name: imply_stack

Overview:
- LIFO that receives implied and decided variable assignments on the push side, which the conflict detector drives.
- On a solver backtrack request it pops entries newest-first, up to and including the most recent decision entry.
- Each popped entry is streamed out so downstream logic (assignment memory, conflict-detector valid bits) can unassign that variable.
- Sits between the conflict detector/decision unit and the solver control FSM.

Parameters:
- VAR_IDX_W, 9, width of a variable index.
- DEPTH, 512, number of stack entries (one per variable; equals MAX_VAR_COUNT).
- PTR_W, $clog2(DEPTH)+1, width of the stack pointer/count (derived, not overridden).

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- push_en  in  1  push request (implication or decision).
- push_var_idx  in  VAR_IDX_W  variable index to push.
- push_val  in  1  assigned value.
- push_decision  in  1  1 = entry is a decision (backtrack boundary), 0 = implication.
- backtrack_req  in  1  single-cycle pulse: start a backtrack.
- flush  in  1  synchronous clear of whole stack; aborts any backtrack.
- pop_valid  out  1  popped entry available.
- pop_ready  in  1  consumer accepts popped entry.
- pop_var_idx  out  VAR_IDX_W  index of popped entry.
- pop_val  out  1  value of popped entry.
- pop_decision  out  1  popped entry is the boundary decision (last pop of this backtrack).
- busy  out  1  backtrack in progress (state != IDLE).
- bt_done  out  1  one-cycle pulse when a backtrack completes.
- bt_no_decision  out  1  qualifies bt_done: stack emptied with no decision found (UNSAT).
- count  out  PTR_W  current number of entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky error: push dropped (full, or during backtrack); cleared by reset or flush.

Behaviour:
- Entry = {var_idx, val, decision}. Storage is a flop array mem[DEPTH]; sp = count.
- Reset (reset==0, async):
  - sp=0, state=IDLE.
  - pop_valid=0, pop_var_idx=0, pop_val=0, pop_decision=0.
  - busy=0, bt_done=0, bt_no_decision=0, overflow=0.
  - Memory contents are not reset.
- Push (IDLE only):
  - If push_en && !full, then mem[sp] <= entry and sp <= sp+1. The entry is visible in count on the next cycle.
  - A push while full is dropped and sets overflow. sp is unchanged.
- FSM states: IDLE, POP, DONE.
- IDLE:
  - On backtrack_req go to POP. If push_en arrives in the same cycle, the push commits first and becomes part of the backtrack.
  - backtrack_req with empty stack goes to DONE with the no-decision flag set.
- POP:
  - pop_valid=1. pop_* is driven combinationally from mem[sp-1].
  - On pop_valid && pop_ready: sp <= sp-1.
    - If the entry's decision bit is 1, go to DONE (flag=0).
    - Else if sp==1 (last entry popped), go to DONE (flag=1).
    - Otherwise stay in POP. One entry per cycle at full throughput.
  - pop_ready low stalls: entry and pop_* are held stable, sp unchanged.
  - push_en in POP or DONE is dropped and sets overflow.
  - backtrack_req outside IDLE is ignored.
- DONE:
  - bt_done=1 for exactly one cycle, with bt_no_decision=flag. Go to IDLE.
  - busy=1 in POP and DONE.
- flush (synchronous, highest priority after reset):
  - sp=0, state=IDLE, pop_valid=0, overflow=0.
  - No bt_done pulse. Any accompanying push is dropped.
- full/empty/count are derived from sp and are combinational.

Decomposition:
- Shared package sat_pkg:
  - MAX_VAR_COUNT=512.
  - var_idx_t (logic [8:0]).
  - imply_entry_t packed struct {var_idx_t var_idx; logic val; logic decision}.
  - imply_stack_state_e enum {IDLE, POP, DONE}.
- One natural sub-module, imply_stack_mem: flop-array LIFO storage with write port at sp and combinational read at sp-1. The FSM, pointer and flags stay in imply_stack.

Test Plan:
- Reset then push decision (idx 5, val 1), then implications (idx 7, val 0) and (idx 9, val 1); backtrack_req with pop_ready=1 -> pops idx 9, 7, 5 on consecutive cycles, pop_decision=1 only on idx 5, then bt_done=1 with bt_no_decision=0, count=0.
- Push two decisions (idx 1 and idx 2) with implication idx 3 on top; backtrack -> pops 3 then 2 only; count=1, top entry = idx 1.
- Push implications only (idx 4, idx 6), then backtrack -> pops 6 and 4, bt_done with bt_no_decision=1; backtrack_req on empty stack -> bt_done on the second cycle with bt_no_decision=1 and no pop_valid.
- Hold pop_ready=0 for 3 cycles mid-backtrack -> pop_var_idx stable, count unchanged; push_en during POP -> dropped, overflow=1; flush -> count=0, overflow=0, busy=0, no bt_done.
- Fill 512 entries -> full=1; 513th push -> dropped, overflow=1, count=512. Same-cycle push_en (idx 8) and backtrack_req in IDLE -> idx 8 is the first entry popped.
- Assert reset=0 mid-POP -> immediately pop_valid=0, busy=0, count=0 without waiting for a clock edge.
